// File: rtl/move_sweep_scheduler_if.sv
// Request/acknowledge link between the movement sweep scheduler and the
// shared position-update datapath. The scheduler is the master: it raises
// upd_req with a stable upd_idx and the datapath answers with upd_ack.
interface move_sweep_scheduler_if #(
  parameter int IDX_W = 3
);
  logic             upd_req;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_ack;

  modport master (output upd_req, output upd_idx, input upd_ack);
  modport slave  (input upd_req, input upd_idx, output upd_ack);
endinterface

// File: rtl/move_sweep_scheduler.sv
// Movement sweep scheduler: generates the movement tick, then walks every
// active object slot in index order and requests one position update per
// slot from the shared datapath. Sweeps are held off while the renderer is
// reading the object table. Ticks that land while a sweep is pending or
// running are dropped and counted as overruns.
// Optional build macro MOVE_SWEEP_ACK_TIMEOUT_EN adds a 16-bit watchdog that
// abandons a slot whose request goes unacknowledged, plus the ack_timeout
// pulse output.
module move_sweep_scheduler #(
  parameter int NUM_OBJ     = 8,
  parameter int IDX_W       = 3,
  parameter int TICK_PERIOD = 2000000,
  parameter int OVR_W       = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [NUM_OBJ-1:0] obj_active,
  input  logic               frame_busy,
  move_sweep_scheduler_if.master upd,
  output logic               sweep_done,
  output logic               tick_overrun,
  output logic [OVR_W-1:0]   overrun_cnt
`ifdef MOVE_SWEEP_ACK_TIMEOUT_EN
  ,
  output logic               ack_timeout
`endif
);

  typedef enum logic [2:0] {IDLE, WAIT_DRAW, SCAN, REQ, DONE} state_t;

  localparam logic [23:0]      TICK_RELOAD = 24'(TICK_PERIOD - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_OBJ - 1);

  state_t             state;
  state_t             state_next;
  logic [23:0]        tick_cnt;
  logic               tick;
  logic [NUM_OBJ-1:0] mask;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   idx_reg;
  logic               slot_hit;
  logic               ptr_last;
  logic               timeout;
  logic               slot_done;
  logic               overrun;

  // reset_n is active-high despite its name
  assign tick      = enable && (tick_cnt == 24'd0);
  assign slot_hit  = mask[ptr];
  assign ptr_last  = (ptr == LAST_IDX);
  assign slot_done = (state == REQ) && (upd.upd_ack || timeout);
  assign overrun   = tick && (state != IDLE);

  assign upd.upd_req = (state == REQ);
  assign upd.upd_idx = idx_reg;
  assign sweep_done  = (state == DONE);

  // Tick down-counter; wrapping through zero gives exactly TICK_PERIOD cycles
  always_ff @(posedge clk) begin
    if (reset_n) begin
      tick_cnt <= TICK_RELOAD;
    end else if (enable) begin
      tick_cnt <= (tick_cnt == 24'd0) ? TICK_RELOAD : tick_cnt - 24'd1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode for the sweep walk
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (tick) begin
          state_next = frame_busy ? WAIT_DRAW : SCAN;
        end
      end
      WAIT_DRAW: begin
        if (!frame_busy) begin
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (slot_hit) begin
          state_next = REQ;
        end else if (ptr_last) begin
          state_next = DONE;
        end
      end
      REQ: begin
        if (slot_done) begin
          state_next = ptr_last ? DONE : SCAN;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sweep datapath: snapshot of active slots, walk pointer, request index
  always_ff @(posedge clk) begin
    if (reset_n) begin
      mask    <= '0;
      ptr     <= '0;
      idx_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tick) begin
            mask <= obj_active;
            ptr  <= '0;
          end
        end
        SCAN: begin
          if (slot_hit) begin
            idx_reg <= ptr;
          end else if (!ptr_last) begin
            ptr <= ptr + IDX_W'(1);
          end
        end
        REQ: begin
          if (slot_done) begin
            mask[ptr] <= 1'b0;
            if (!ptr_last) begin
              ptr <= ptr + IDX_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Overrun pulse and saturating overrun counter
  always_ff @(posedge clk) begin
    if (reset_n) begin
      tick_overrun <= 1'b0;
      overrun_cnt  <= '0;
    end else begin
      tick_overrun <= overrun;
      if (overrun && (overrun_cnt != {OVR_W{1'b1}})) begin
        overrun_cnt <= overrun_cnt + OVR_W'(1);
      end
    end
  end

`ifdef MOVE_SWEEP_ACK_TIMEOUT_EN
  logic [15:0] wd_cnt;

  // Abandon the slot once 65535 REQ cycles have passed without an ack
  assign timeout = (state == REQ) && !upd.upd_ack && (wd_cnt == 16'hFFFE);

  // Watchdog counts cycles spent in REQ and flags an abandoned slot
  always_ff @(posedge clk) begin
    if (reset_n) begin
      wd_cnt      <= '0;
      ack_timeout <= 1'b0;
    end else begin
      ack_timeout <= timeout;
      wd_cnt      <= (state == REQ) ? wd_cnt + 16'd1 : 16'd0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_move_sweep_scheduler.sv
// Self-checking bench for move_sweep_scheduler. Expected request indices,
// sweep_done cycles and overrun cycles are queued as each scenario is set up
// and popped as the design produces them. Cycle numbers n count rising edges
// since the reset edge; a tick lands in cycle 15 after every reset.
module tb_move_sweep_scheduler;
  localparam int NUM_OBJ     = 8;
  localparam int IDX_W       = 3;
  localparam int TICK_PERIOD = 16;
  localparam int OVR_W       = 8;

  logic               clk        = 1'b0;
  logic               reset_n    = 1'b1;
  logic               enable     = 1'b1;
  logic               frame_busy = 1'b0;
  logic [NUM_OBJ-1:0] obj_active = '0;
  logic               sweep_done;
  logic               tick_overrun;
  logic [OVR_W-1:0]   overrun_cnt;
`ifdef MOVE_SWEEP_ACK_TIMEOUT_EN
  logic               ack_timeout;
`endif

  int compared   = 0;
  int mismatched = 0;
  int idx_q[$];
  int done_q[$];
  int ovr_q[$];

  move_sweep_scheduler_if #(.IDX_W(IDX_W)) bus ();

  move_sweep_scheduler #(
    .NUM_OBJ(NUM_OBJ), .IDX_W(IDX_W), .TICK_PERIOD(TICK_PERIOD), .OVR_W(OVR_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .obj_active(obj_active),
    .frame_busy(frame_busy),
    .upd(bus),
    .sweep_done(sweep_done),
    .tick_overrun(tick_overrun),
    .overrun_cnt(overrun_cnt)
`ifdef MOVE_SWEEP_ACK_TIMEOUT_EN
    ,
    .ack_timeout(ack_timeout)
`endif
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset_n     = 1'b1;
    bus.upd_ack = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    idx_q.delete();
    done_q.delete();
    ovr_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    compared++;
    if (bus.upd_req !== 1'b0) begin
      mismatched++; $display("[TB] FAIL reset_upd_req: got %0b expected 0", bus.upd_req);
    end
    compared++;
    if (bus.upd_idx !== 3'd0) begin
      mismatched++; $display("[TB] FAIL reset_upd_idx: got %0d expected 0", bus.upd_idx);
    end
    compared++;
    if (sweep_done !== 1'b0) begin
      mismatched++; $display("[TB] FAIL reset_sweep_done: got %0b expected 0", sweep_done);
    end
    compared++;
    if (tick_overrun !== 1'b0) begin
      mismatched++; $display("[TB] FAIL reset_tick_overrun: got %0b expected 0", tick_overrun);
    end
    compared++;
    if (overrun_cnt !== 8'd0) begin
      mismatched++; $display("[TB] FAIL reset_overrun_cnt: got %0d expected 0", overrun_cnt);
    end
  endtask

  task automatic test_tick_period();
    int exp;
    do_reset();
    obj_active = '0; frame_busy = 1'b0; enable = 1'b1;
    done_q.push_back(24); done_q.push_back(40); done_q.push_back(56);
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      compared++;
      if (bus.upd_req !== 1'b0) begin
        mismatched++; $display("[TB] FAIL idle_upd_req n=%0d: got %0b expected 0", n, bus.upd_req);
      end
      if (sweep_done === 1'b1) begin
        compared++;
        if (done_q.size() == 0) begin
          mismatched++; $display("[TB] FAIL tick_done_extra: got pulse at %0d expected none", n);
        end else begin
          exp = done_q.pop_front();
          if (n !== exp) begin
            mismatched++; $display("[TB] FAIL tick_done_cycle: got %0d expected %0d", n, exp);
          end
        end
      end
    end
    compared++;
    if (done_q.size() != 0) begin
      mismatched++; $display("[TB] FAIL tick_done_missing: got %0d left expected 0", done_q.size());
    end
  endtask

  task automatic test_sweep_pattern();
    int age = 0, pairs = 0, first_req = -1, exp;
    do_reset();
    obj_active = 8'b1010_0101; frame_busy = 1'b0; enable = 1'b1;
    idx_q.push_back(0); idx_q.push_back(2); idx_q.push_back(5); idx_q.push_back(7);
    done_q.push_back(32);
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      if (n == 16) enable = 1'b0;
      if (bus.upd_req === 1'b1) begin
        if (first_req < 0) first_req = n;
        age++;
        if (age == 2) begin
          bus.upd_ack = 1'b1;
          pairs++;
          compared++;
          if (idx_q.size() == 0) begin
            mismatched++; $display("[TB] FAIL pattern_idx_extra: got %0d expected none", bus.upd_idx);
          end else begin
            exp = idx_q.pop_front();
            if (int'(bus.upd_idx) !== exp) begin
              mismatched++; $display("[TB] FAIL pattern_idx: got %0d expected %0d", bus.upd_idx, exp);
            end
          end
        end else begin
          bus.upd_ack = 1'b0;
        end
      end else begin
        age = 0; bus.upd_ack = 1'b0;
      end
      if (sweep_done === 1'b1) begin
        compared++;
        exp = (done_q.size() == 0) ? -1 : done_q.pop_front();
        if (n !== exp) begin
          mismatched++; $display("[TB] FAIL pattern_done_cycle: got %0d expected %0d", n, exp);
        end
      end
    end
    bus.upd_ack = 1'b0;
    enable = 1'b1;
    compared++;
    if (first_req !== 17) begin
      mismatched++; $display("[TB] FAIL pattern_first_req: got %0d expected 17", first_req);
    end
    compared++;
    if (pairs !== 4) begin
      mismatched++; $display("[TB] FAIL pattern_pairs: got %0d expected 4", pairs);
    end
    compared++;
    if (done_q.size() != 0 || idx_q.size() != 0) begin
      mismatched++; $display("[TB] FAIL pattern_leftover: got %0d/%0d expected 0/0", done_q.size(), idx_q.size());
    end
    compared++;
    if (overrun_cnt !== 8'd0) begin
      mismatched++; $display("[TB] FAIL pattern_overrun: got %0d expected 0", overrun_cnt);
    end
  endtask

  task automatic test_frame_busy();
    int age = 0, first_req = -1, exp;
    do_reset();
    obj_active = 8'b0000_1100; frame_busy = 1'b1; enable = 1'b1;
    idx_q.push_back(2); idx_q.push_back(3);
    done_q.push_back(48);
    for (int n = 1; n <= 55; n++) begin
      @(negedge clk);
      if (n == 16) enable = 1'b0;
      if (n == 18) obj_active = 8'hFF;
      if (n == 35) frame_busy = 1'b0;
      if (n == 40) frame_busy = 1'b1;
      if (bus.upd_req === 1'b1) begin
        if (first_req < 0) first_req = n;
        age++;
        if (age == 2) begin
          bus.upd_ack = 1'b1;
          compared++;
          exp = (idx_q.size() == 0) ? -1 : idx_q.pop_front();
          if (int'(bus.upd_idx) !== exp) begin
            mismatched++; $display("[TB] FAIL busy_idx: got %0d expected %0d", bus.upd_idx, exp);
          end
        end else begin
          bus.upd_ack = 1'b0;
        end
      end else begin
        age = 0; bus.upd_ack = 1'b0;
      end
      if (sweep_done === 1'b1) begin
        compared++;
        exp = (done_q.size() == 0) ? -1 : done_q.pop_front();
        if (n !== exp) begin
          mismatched++; $display("[TB] FAIL busy_done_cycle: got %0d expected %0d", n, exp);
        end
      end
    end
    bus.upd_ack = 1'b0; frame_busy = 1'b0; enable = 1'b1;
    compared++;
    if (first_req !== 39) begin
      mismatched++; $display("[TB] FAIL busy_first_req: got %0d expected 39", first_req);
    end
    compared++;
    if (done_q.size() != 0 || idx_q.size() != 0) begin
      mismatched++; $display("[TB] FAIL busy_leftover: got %0d/%0d expected 0/0", done_q.size(), idx_q.size());
    end
  endtask

  task automatic test_overrun();
    int age = 0, pairs = 0, first_req = -1, exp;
    do_reset();
    obj_active = 8'b0000_0001; frame_busy = 1'b0; enable = 1'b1;
    idx_q.push_back(0);
    ovr_q.push_back(32); ovr_q.push_back(48);
    done_q.push_back(64);
    for (int n = 1; n <= 70; n++) begin
      @(negedge clk);
      if (n == 50) enable = 1'b0;
      if (bus.upd_req === 1'b1) begin
        if (first_req < 0) first_req = n;
        age++;
        compared++;
        if (bus.upd_idx !== 3'd0) begin
          mismatched++; $display("[TB] FAIL ovr_idx_hold n=%0d: got %0d expected 0", n, bus.upd_idx);
        end
        if (age == 40) begin
          bus.upd_ack = 1'b1;
          pairs++;
          void'(idx_q.pop_front());
        end else begin
          bus.upd_ack = 1'b0;
        end
      end else begin
        age = 0; bus.upd_ack = 1'b0;
      end
      if (tick_overrun === 1'b1) begin
        compared++;
        exp = (ovr_q.size() == 0) ? -1 : ovr_q.pop_front();
        if (n !== exp) begin
          mismatched++; $display("[TB] FAIL ovr_pulse_cycle: got %0d expected %0d", n, exp);
        end
      end
      if (sweep_done === 1'b1) begin
        compared++;
        exp = (done_q.size() == 0) ? -1 : done_q.pop_front();
        if (n !== exp) begin
          mismatched++; $display("[TB] FAIL ovr_done_cycle: got %0d expected %0d", n, exp);
        end
      end
    end
    bus.upd_ack = 1'b0; enable = 1'b1;
    compared++;
    if (overrun_cnt !== 8'd2) begin
      mismatched++; $display("[TB] FAIL ovr_count: got %0d expected 2", overrun_cnt);
    end
    compared++;
    if (first_req !== 17 || pairs !== 1) begin
      mismatched++; $display("[TB] FAIL ovr_req: got first=%0d pairs=%0d expected 17/1", first_req, pairs);
    end
    compared++;
    if (ovr_q.size() != 0 || done_q.size() != 0) begin
      mismatched++; $display("[TB] FAIL ovr_leftover: got %0d/%0d expected 0/0", ovr_q.size(), done_q.size());
    end
  endtask

  task automatic test_reset_mid_sweep();
    int age = 0, first_req = -1, exp;
    do_reset();
    obj_active = 8'b0001_0000; frame_busy = 1'b0; enable = 1'b1;
    for (int n = 1; n <= 35; n++) begin
      @(negedge clk);
      compared++;
      if (sweep_done !== 1'b0) begin
        mismatched++; $display("[TB] FAIL mid_no_done n=%0d: got %0b expected 0", n, sweep_done);
      end
    end
    compared++;
    if (bus.upd_req !== 1'b1 || bus.upd_idx !== 3'd4 || overrun_cnt !== 8'd1) begin
      mismatched++;
      $display("[TB] FAIL mid_pre_reset: got req=%0b idx=%0d ovr=%0d expected 1/4/1", bus.upd_req, bus.upd_idx, overrun_cnt);
    end
    reset_n = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    compared++;
    if (bus.upd_req !== 1'b0 || overrun_cnt !== 8'd0 || sweep_done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mid_post_reset: got req=%0b ovr=%0d done=%0b expected 0/0/0", bus.upd_req, overrun_cnt, sweep_done);
    end
    idx_q.push_back(4);
    done_q.push_back(26);
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (bus.upd_req === 1'b1) begin
        if (first_req < 0) first_req = n;
        age++;
        if (age == 2) begin
          bus.upd_ack = 1'b1;
          compared++;
          exp = (idx_q.size() == 0) ? -1 : idx_q.pop_front();
          if (int'(bus.upd_idx) !== exp) begin
            mismatched++; $display("[TB] FAIL mid_idx: got %0d expected %0d", bus.upd_idx, exp);
          end
        end else begin
          bus.upd_ack = 1'b0;
        end
      end else begin
        age = 0; bus.upd_ack = 1'b0;
      end
      if (sweep_done === 1'b1) begin
        compared++;
        exp = (done_q.size() == 0) ? -1 : done_q.pop_front();
        if (n !== exp) begin
          mismatched++; $display("[TB] FAIL mid_done_cycle: got %0d expected %0d", n, exp);
        end
      end
    end
    bus.upd_ack = 1'b0;
    compared++;
    if (first_req !== 21 || done_q.size() != 0) begin
      mismatched++; $display("[TB] FAIL mid_resume: got first=%0d left=%0d expected 21/0", first_req, done_q.size());
    end
  endtask

`ifdef MOVE_SWEEP_ACK_TIMEOUT_EN
  task automatic test_ack_timeout();
    int age = 0, run0 = 0, exp;
    do_reset();
    obj_active = 8'b0000_0011; frame_busy = 1'b0; enable = 1'b1;
    idx_q.push_back(1);
    ovr_q.push_back(65552);
    done_q.push_back(65561);
    for (int n = 1; n <= 65600; n++) begin
      @(negedge clk);
      if (n == 16) enable = 1'b0;
      if (bus.upd_req === 1'b1) begin
        age++;
        if (bus.upd_idx === 3'd0) run0++;
        if (bus.upd_idx !== 3'd0 && age == 2) begin
          bus.upd_ack = 1'b1;
          compared++;
          exp = (idx_q.size() == 0) ? -1 : idx_q.pop_front();
          if (int'(bus.upd_idx) !== exp) begin
            mismatched++; $display("[TB] FAIL wd_idx: got %0d expected %0d", bus.upd_idx, exp);
          end
        end else begin
          bus.upd_ack = 1'b0;
        end
      end else begin
        age = 0; bus.upd_ack = 1'b0;
      end
      if (ack_timeout === 1'b1) begin
        compared++;
        exp = (ovr_q.size() == 0) ? -1 : ovr_q.pop_front();
        if (n !== exp) begin
          mismatched++; $display("[TB] FAIL wd_pulse_cycle: got %0d expected %0d", n, exp);
        end
      end
      if (sweep_done === 1'b1) begin
        compared++;
        exp = (done_q.size() == 0) ? -1 : done_q.pop_front();
        if (n !== exp) begin
          mismatched++; $display("[TB] FAIL wd_done_cycle: got %0d expected %0d", n, exp);
        end
      end
    end
    bus.upd_ack = 1'b0; enable = 1'b1;
    compared++;
    if (run0 !== 65535 || ovr_q.size() != 0 || idx_q.size() != 0) begin
      mismatched++; $display("[TB] FAIL wd_run: got %0d cycles left=%0d expected 65535/0", run0, ovr_q.size());
    end
  endtask
`endif

  initial begin
    bus.upd_ack = 1'b0;
    test_reset();
    test_tick_period();
    test_sweep_pattern();
    test_frame_busy();
    test_overrun();
    test_reset_mid_sweep();
`ifdef MOVE_SWEEP_ACK_TIMEOUT_EN
    test_ack_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/move_sweep_scheduler.md
Name: move_sweep_scheduler

Overview:
- Schedules per-object position updates for the game-object table.
- Generates the movement tick internally, then sweeps all active object slots in index order.
- Issues one request per active slot to the shared position-update datapath over a req/ack handshake.
- Sits between the object table (slot activity flags) and the single update datapath, and defers sweeps while the frame renderer is busy.

Parameters:
- NUM_OBJ, 8, number of object slots (power of two, 2..64).
- IDX_W, 3, width of slot index (log2 NUM_OBJ).
- TICK_PERIOD, 2000000, clock cycles between movement ticks (2..2^24).
- OVR_W, 8, width of overrun counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset.
- enable  in  1  tick counter runs when high.
- obj_active  in  NUM_OBJ  per-slot active flag, sampled at tick.
- frame_busy  in  1  renderer is reading the object table; a sweep must not start while high.
- upd_req  out  1  update request to datapath.
- upd_idx  out  IDX_W  slot index for the current request.
- upd_ack  in  1  datapath accepted/finished the slot.
- sweep_done  out  1  one-cycle pulse at sweep completion.
- tick_overrun  out  1  one-cycle pulse when a tick arrives while a sweep is still pending or running.
- overrun_cnt  out  OVR_W  saturating count of overruns.

Behaviour:
- Clock and reset (already decided): one clock, clk; reset is synchronous and active-high on reset_n. reset_n=1 is reset despite the _n suffix.
- Reset values:
  - upd_req=0, upd_idx=0, sweep_done=0, tick_overrun=0, overrun_cnt=0.
  - State IDLE; tick counter loaded with TICK_PERIOD-1; sweep mask cleared.
- Tick counter (24 bits):
  - Decrements each cycle while enable=1 and holds while enable=0.
  - At value 0 with enable=1: internal tick=1 for that cycle, and the counter reloads TICK_PERIOD-1 next edge.
  - Result: tick period is exactly TICK_PERIOD cycles.
- States:
  - IDLE: on tick, latch mask<=obj_active and ptr<=0. Go to WAIT_DRAW if frame_busy=1, else SCAN.
  - WAIT_DRAW: stay until frame_busy=0, then go to SCAN next edge.
  - SCAN: one slot per cycle.
    - If mask[ptr]=1: go to REQ with upd_idx<=ptr.
    - Else if ptr==NUM_OBJ-1: go to DONE.
    - Else ptr<=ptr+1.
  - REQ: upd_req=1 with upd_idx held stable until upd_ack=1 is sampled. On ack:
    - upd_req<=0 and mask[ptr]<=0.
    - If ptr==NUM_OBJ-1, go to DONE; else ptr<=ptr+1 and go to SCAN.
  - DONE: sweep_done=1 for one cycle, then IDLE.
- Handshake rules:
  - upd_req is never deasserted without an ack.
  - upd_ack while upd_req=0 is ignored.
  - Ack on the first REQ cycle is legal, giving a minimum 2 cycles per active slot.
- Latency:
  - Tick to first upd_req: ptr_first+2 cycles when frame_busy=0.
  - Tick to sweep_done with no active slots: NUM_OBJ+1 cycles.
- Overrun:
  - A tick in any state other than IDLE is dropped.
  - tick_overrun pulses for one cycle and overrun_cnt increments, saturating at all-ones.
- obj_active changes after the tick-cycle latch do not affect the current sweep.
- frame_busy is consulted only before a sweep starts. Rising frame_busy mid-sweep has no effect.
- enable=0 does not abort a sweep; the sweep in progress completes.
- Reset asserted mid-sweep: next edge gives upd_req=0 and IDLE, with no sweep_done pulse.

Optional Feature:
- Macro: MOVE_SWEEP_ACK_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog counts REQ cycles.
  - After 65535 cycles without ack, the slot is abandoned: upd_req<=0, mask bit cleared, sweep advances as if acked.
  - Adds output ack_timeout (1 bit), a one-cycle pulse on abandon.
- Undefined: no watchdog; REQ waits indefinitely. The ack_timeout port does not exist.

Test Plan:
- TICK_PERIOD=16, enable=1, obj_active=0 -> tick every 16 cycles; sweep_done 9 cycles after each tick; upd_req never asserted.
- obj_active=8'b1010_0101, frame_busy=0, upd_ack one cycle after each req -> upd_idx sequence 0,2,5,7; exactly 4 req/ack pairs; one sweep_done.
- frame_busy=1 at tick, held 20 cycles -> no upd_req during those 20 cycles; sweep starts at frame_busy fall; obj_active changed during the wait is ignored.
- TICK_PERIOD=16 with upd_ack withheld 40 cycles on slot 0 -> two tick_overrun pulses; overrun_cnt=2; upd_idx stays 0 with upd_req high until ack.
- Assert reset_n for 1 cycle while in REQ -> next cycle upd_req=0 and overrun_cnt=0; counter restarts at 15; next sweep behaves normally.
- With MOVE_SWEEP_ACK_TIMEOUT_EN defined, obj_active=8'b0000_0011, never ack slot 0 -> ack_timeout pulse after 65535 REQ cycles; upd_idx advances to 1.
